// File: rtl/hps_subsys_reset_sequencer.sv
// HPS subsystem reset sequencer.
// Releases the EMIF, USB3.1 PHY, USB3.1 controller and fabric resets in order once the device
// is in user mode. It waits for EMIF calibration and PHY PLL lock, applies timeouts and
// automatic retries, and reports status.
module hps_subsys_reset_sequencer #(
   parameter int unsigned SETTLE_CYC    = 16,
   parameter int unsigned RST_PULSE_CYC = 64,
   parameter int unsigned EMIF_TIMEOUT  = 2000000,
   parameter int unsigned PHY_TIMEOUT   = 500000,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic       clk_100_clk,
   input  logic       reset_reset_n,
   input  logic       ninit_done,
   input  logic       emif_cal_success,
   input  logic       emif_cal_fail,
   input  logic       usb_phy_pll_locked,
   input  logic       restart_req,
   output logic       emif_reset_n,
   output logic       usb_phy_reset_n,
   output logic       usb_ctrl_reset_n,
   output logic       fabric_reset_n,
   output logic       seq_done,
   output logic       seq_error,
   output logic [2:0] err_code,
   output logic [3:0] seq_state
);

   localparam int unsigned MaxTo   = (EMIF_TIMEOUT > PHY_TIMEOUT) ? EMIF_TIMEOUT : PHY_TIMEOUT;
   // The counter also times reset pulses and settle windows, so size it for the largest of all.
   localparam int unsigned MaxAux  = (RST_PULSE_CYC > SETTLE_CYC) ? RST_PULSE_CYC : SETTLE_CYC;
   localparam int unsigned MaxCnt  = (MaxTo > MaxAux) ? MaxTo : MaxAux;
   localparam int unsigned CntW    = $clog2(MaxCnt + 1);
   localparam int unsigned SetW    = $clog2(SETTLE_CYC + 1);
   localparam int unsigned RetryW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [CntW-1:0]   CntOne     = CntW'(1);
   localparam logic [SetW-1:0]   SetOne     = SetW'(1);
   localparam logic [RetryW-1:0] RetryOne   = RetryW'(1);
   localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE_CYC - 1);
   localparam logic [SetW-1:0]   SetLast    = SetW'(SETTLE_CYC - 1);
   localparam logic [CntW-1:0]   PulseLast  = CntW'(RST_PULSE_CYC - 1);
   localparam logic [CntW-1:0]   EmifLast   = CntW'(EMIF_TIMEOUT - 1);
   localparam logic [CntW-1:0]   PhyLast    = CntW'(PHY_TIMEOUT - 1);
   localparam logic [RetryW-1:0] MaxRetry   = RetryW'(MAX_RETRY);

   // Synchroniser reset value: ninit_done idles at 1 (device not yet in user mode).
   localparam logic [3:0] SyncRst = 4'b1000;

   typedef enum logic [3:0] {
      StWaitInit  = 4'd0,
      StEmifRst   = 4'd1,
      StEmifCal   = 4'd2,
      StPhyRst    = 4'd3,
      StPhyLock   = 4'd4,
      StCtrlRel   = 4'd5,
      StFabricRel = 4'd6,
      StRun       = 4'd7,
      StError     = 4'd8
   } state_e;

   logic [3:0]        sync_q [SYNC_STAGES];
   logic              ninit_s, cal_ok_s, cal_fail_s, locked_s;

   state_e            state_q, state_d;
   logic              enter;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [SetW-1:0]   set_q, set_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [2:0]        err_q, err_d;

   // Multi-flop synchroniser for all asynchronous status levels.
   always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SyncRst;
      end else begin
         sync_q[0] <= {ninit_done, emif_cal_success, emif_cal_fail, usb_phy_pll_locked};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign {ninit_s, cal_ok_s, cal_fail_s, locked_s} = sync_q[SYNC_STAGES-1];

   // Next-state, error code, retry count and cycle counters.
   always_comb begin
      state_d = state_q;
      enter   = 1'b0;
      err_d   = err_q;
      retry_d = retry_q;
      cnt_d   = cnt_q;
      set_d   = set_q;

      if (restart_req && (state_q != StRun) && (state_q != StError)) begin
         state_d = StWaitInit;
         enter   = 1'b1;
      end else begin
         case (state_q)
            StWaitInit: begin
               if (!ninit_s && (cnt_q == SettleLast)) begin
                  state_d = StEmifRst;
                  enter   = 1'b1;
               end
            end
            StEmifRst: begin
               if (cnt_q == PulseLast) begin
                  state_d = StEmifCal;
                  enter   = 1'b1;
               end
            end
            StEmifCal: begin
               // Fail beats success, and any response beats the timeout on the same cycle.
               if (cal_fail_s) begin
                  state_d = StError;
                  err_d   = 3'd1;
                  enter   = 1'b1;
               end else if (cal_ok_s) begin
                  state_d = StPhyRst;
                  enter   = 1'b1;
               end else if (cnt_q == EmifLast) begin
                  state_d = StError;
                  err_d   = 3'd2;
                  enter   = 1'b1;
               end
            end
            StPhyRst: begin
               if (cnt_q == PulseLast) begin
                  state_d = StPhyLock;
                  enter   = 1'b1;
               end
            end
            StPhyLock: begin
               if (locked_s && (set_q == SetLast)) begin
                  state_d = StCtrlRel;
                  enter   = 1'b1;
               end else if (cnt_q == PhyLast) begin
                  state_d = StError;
                  err_d   = 3'd3;
                  enter   = 1'b1;
               end
            end
            StCtrlRel: begin
               if (cnt_q == SettleLast) begin
                  state_d = StFabricRel;
                  enter   = 1'b1;
               end
            end
            StFabricRel: begin
               state_d = StRun;
               retry_d = '0;
               err_d   = 3'd0;
               enter   = 1'b1;
            end
            StRun: begin
               if (ninit_s) begin
                  state_d = StWaitInit;
                  enter   = 1'b1;
               end else if (!locked_s) begin
                  state_d = StError;
                  err_d   = 3'd4;
                  enter   = 1'b1;
               end else if (restart_req) begin
                  state_d = StWaitInit;
                  enter   = 1'b1;
               end
            end
            StError: begin
               if (retry_q < MaxRetry) begin
                  if (cnt_q == PulseLast) begin
                     retry_d = retry_q + RetryOne;
                     state_d = StWaitInit;
                     enter   = 1'b1;
                  end
               end else if (restart_req) begin
                  retry_d = '0;
                  state_d = StWaitInit;
                  enter   = 1'b1;
               end
            end
            default: begin
               state_d = StWaitInit;
               enter   = 1'b1;
            end
         endcase
      end

      // cnt restarts on every state entry; in WAIT_INIT it counts consecutive user-mode cycles,
      // and in PHY_LOCK set counts consecutive lock cycles alongside the total in cnt.
      if (enter) begin
         cnt_d = '0;
         set_d = '0;
      end else begin
         case (state_q)
            StWaitInit: cnt_d = ninit_s ? '0 : cnt_q + CntOne;
            StPhyLock: begin
               cnt_d = cnt_q + CntOne;
               set_d = locked_s ? set_q + SetOne : '0;
            end
            StRun:      cnt_d = cnt_q;
            StError:    if (retry_q < MaxRetry) cnt_d = cnt_q + CntOne;
            default:    cnt_d = cnt_q + CntOne;
         endcase
      end
   end

   // FSM state plus registered outputs decoded from the current state (one cycle behind it).
   always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q          <= StWaitInit;
         cnt_q            <= '0;
         set_q            <= '0;
         retry_q          <= '0;
         err_q            <= 3'd0;
         emif_reset_n     <= 1'b0;
         usb_phy_reset_n  <= 1'b0;
         usb_ctrl_reset_n <= 1'b0;
         fabric_reset_n   <= 1'b0;
         seq_done         <= 1'b0;
         seq_error        <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         set_q            <= set_d;
         retry_q          <= retry_d;
         err_q            <= err_d;
         emif_reset_n     <= state_q inside {StEmifCal, StPhyRst, StPhyLock, StCtrlRel,
                                             StFabricRel, StRun};
         usb_phy_reset_n  <= state_q inside {StPhyLock, StCtrlRel, StFabricRel, StRun};
         usb_ctrl_reset_n <= state_q inside {StCtrlRel, StFabricRel, StRun};
         fabric_reset_n   <= state_q inside {StFabricRel, StRun};
         seq_done         <= (state_q == StRun);
         seq_error        <= (state_q == StError);
      end
   end

   assign err_code  = err_q;
   assign seq_state = state_q;

endmodule

// File: tb/tb_hps_subsys_reset_sequencer.sv
// Bench for hps_subsys_reset_sequencer: directed scenarios plus a randomized soak, all checked
// cycle by cycle against a phase-level reference model.
module tb_hps_subsys_reset_sequencer;

   localparam int SETTLE = 4;
   localparam int PULSE  = 8;
   localparam int EMIF_TO = 100;
   localparam int PHY_TO  = 50;
   localparam int MAXR    = 1;
   localparam int SYNC    = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ninit_done, emif_cal_success, emif_cal_fail, usb_phy_pll_locked, restart_req;
   logic       emif_reset_n, usb_phy_reset_n, usb_ctrl_reset_n, fabric_reset_n;
   logic       seq_done, seq_error;
   logic [2:0] err_code;
   logic [3:0] seq_state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hps_subsys_reset_sequencer #(
      .SETTLE_CYC    (SETTLE),
      .RST_PULSE_CYC (PULSE),
      .EMIF_TIMEOUT  (EMIF_TO),
      .PHY_TIMEOUT   (PHY_TO),
      .MAX_RETRY     (MAXR),
      .SYNC_STAGES   (SYNC)
   ) dut (
      .clk_100_clk        (clk),
      .reset_reset_n      (rst_n),
      .ninit_done         (ninit_done),
      .emif_cal_success   (emif_cal_success),
      .emif_cal_fail      (emif_cal_fail),
      .usb_phy_pll_locked (usb_phy_pll_locked),
      .restart_req        (restart_req),
      .emif_reset_n       (emif_reset_n),
      .usb_phy_reset_n    (usb_phy_reset_n),
      .usb_ctrl_reset_n   (usb_ctrl_reset_n),
      .fabric_reset_n     (fabric_reset_n),
      .seq_done           (seq_done),
      .seq_error          (seq_error),
      .err_code           (err_code),
      .seq_state          (seq_state)
   );

   // Reference model: sequence phase, cycles spent in it, current good-level run length.
   typedef enum {PWait, PEmifRst, PEmifCal, PPhyRst, PPhyLock, PCtrl, PFabric, PRun, PErr} phase_e;

   phase_e     m_phase, m_out;
   int         m_tin, m_run, m_retry, m_err;
   logic [3:0] m_hist [$];

   // Number of resets released in a phase; releases are always a prefix of the order.
   function automatic int rel_level(input phase_e p);
      case (p)
         PEmifCal, PPhyRst: return 1;
         PPhyLock:          return 2;
         PCtrl:             return 3;
         PFabric, PRun:     return 4;
         default:           return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = PWait;
      m_out   = PWait;
      m_tin   = 0;
      m_run   = 0;
      m_retry = 0;
      m_err   = 0;
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(4'b1000);
   endtask

   task automatic model_edge();
      logic [3:0] s;
      logic       ninit_s, ok_s, fail_s, lock_s;
      phase_e     nxt;
      bit         moved;
      int         n;
      s = m_hist.pop_front();
      m_hist.push_back({ninit_done, emif_cal_success, emif_cal_fail, usb_phy_pll_locked});
      {ninit_s, ok_s, fail_s, lock_s} = s;
      m_out = m_phase;
      n     = m_tin + 1;
      nxt   = m_phase;
      moved = 1'b0;
      if (restart_req && m_phase != PRun && m_phase != PErr) begin
         nxt = PWait; moved = 1'b1;
      end else begin
         case (m_phase)
            PWait: begin
               m_run = ninit_s ? 0 : m_run + 1;
               if (m_run == SETTLE) begin nxt = PEmifRst; moved = 1'b1; end
            end
            PEmifRst: if (n == PULSE) begin nxt = PEmifCal; moved = 1'b1; end
            PEmifCal: begin
               if (fail_s)             begin nxt = PErr; m_err = 1; moved = 1'b1; end
               else if (ok_s)          begin nxt = PPhyRst; moved = 1'b1; end
               else if (n == EMIF_TO)  begin nxt = PErr; m_err = 2; moved = 1'b1; end
            end
            PPhyRst: if (n == PULSE) begin nxt = PPhyLock; moved = 1'b1; end
            PPhyLock: begin
               m_run = lock_s ? m_run + 1 : 0;
               if (m_run == SETTLE)    begin nxt = PCtrl; moved = 1'b1; end
               else if (n == PHY_TO)   begin nxt = PErr; m_err = 3; moved = 1'b1; end
            end
            PCtrl: if (n == SETTLE) begin nxt = PFabric; moved = 1'b1; end
            PFabric: begin nxt = PRun; m_retry = 0; m_err = 0; moved = 1'b1; end
            PRun: begin
               if (ninit_s)            begin nxt = PWait; moved = 1'b1; end
               else if (!lock_s)       begin nxt = PErr; m_err = 4; moved = 1'b1; end
               else if (restart_req)   begin nxt = PWait; moved = 1'b1; end
            end
            PErr: begin
               if (m_retry < MAXR) begin
                  if (n == PULSE) begin m_retry++; nxt = PWait; moved = 1'b1; end
               end else if (restart_req) begin
                  m_retry = 0; nxt = PWait; moved = 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (moved) begin
         m_phase = nxt; m_tin = 0; m_run = 0;
      end else begin
         m_tin++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_now();
      logic [8:0] obs, exp;
      int         lvl;
      obs = {emif_reset_n, usb_phy_reset_n, usb_ctrl_reset_n, fabric_reset_n,
             seq_done, seq_error, err_code};
      lvl = rel_level(m_out);
      exp = {lvl >= 1, lvl >= 2, lvl >= 3, lvl >= 4, m_out == PRun, m_out == PErr, 3'(m_err)};
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL outputs @%0t: got %b, want %b", $time, obs, exp);
      end
      n_tests++;
      assert (((emif_reset_n | ~usb_phy_reset_n) & (usb_phy_reset_n | ~usb_ctrl_reset_n) &
               (usb_ctrl_reset_n | ~fabric_reset_n)) === 1'b1) else begin
         n_fail++;
         $error("FAIL order @%0t: got %b, want ordered", $time, obs[8:5]);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_now();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_phase(input phase_e p, input int budget, input string tag);
      int k;
      k = 0;
      while (m_phase != p && k < budget) begin
         cycle();
         k++;
      end
      n_tests++;
      assert (m_phase == p) else begin
         n_fail++;
         $error("FAIL %s: got no arrival within %0d cycles, want phase %0d", tag, budget, p);
      end
   endtask

   // Asynchronous reset between clock edges; outputs must clear without waiting for an edge.
   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_now();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_now();
   endtask

   initial begin
      logic [7:0] glitch;
      rst_n = 1'b0;
      ninit_done = 1'b1; emif_cal_success = 1'b0; emif_cal_fail = 1'b0;
      usb_phy_pll_locked = 1'b0; restart_req = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_emif", 32'(emif_reset_n), 0);
      chk("rst_fabric", 32'(fabric_reset_n), 0);
      chk("rst_done", 32'(seq_done), 0);
      chk("rst_err", 32'(err_code), 0);
      rst_n = 1'b1;
      check_now();

      // Happy path.
      run(3 + int'($urandom_range(0, 3)));
      ninit_done = 1'b0;
      wait_phase(PEmifCal, 60, "happy_cal");
      run(19);
      emif_cal_success = 1'b1;
      wait_phase(PPhyLock, 60, "happy_lock");
      run(9);
      usb_phy_pll_locked = 1'b1;
      wait_phase(PRun, 60, "happy_run");
      run(2);
      chk("happy_done", 32'(seq_done), 1);
      chk("happy_fabric", 32'(fabric_reset_n), 1);
      chk("happy_err", 32'(err_code), 0);

      // Lock loss in RUN, auto-retry, then PHY lock timeout with retries exhausted.
      usb_phy_pll_locked = 1'b0;
      wait_phase(PErr, 10, "runloss_err");
      cycle();
      chk("runloss_code", 32'(err_code), 4);
      chk("runloss_fabric", 32'(fabric_reset_n), 0);
      chk("runloss_phy", 32'(usb_phy_reset_n), 0);
      chk("runloss_seqerr", 32'(seq_error), 1);
      wait_phase(PPhyLock, 60, "retry_lock");
      wait_phase(PErr, 60, "phy_timeout");
      cycle();
      chk("phy_to_code", 32'(err_code), 3);
      run(30);
      chk("stuck_seqerr", 32'(seq_error), 1);
      restart_req = 1'b1;
      cycle();
      restart_req = 1'b0;
      run(2);
      chk("restart_seqerr", 32'(seq_error), 0);

      // PHY lock glitch: 3 high, 1 low, 4 high.
      wait_phase(PPhyLock, 60, "glitch_lock");
      glitch = 8'b11101111;
      for (int i = 7; i >= 0; i--) begin
         usb_phy_pll_locked = glitch[i];
         cycle();
      end
      run(2);
      chk("glitch_ctrl_lo", 32'(usb_ctrl_reset_n), 0);
      cycle();
      chk("glitch_ctrl_hi", 32'(usb_ctrl_reset_n), 1);
      wait_phase(PRun, 20, "glitch_run");

      // Leaving user mode while in RUN.
      ninit_done = 1'b1;
      wait_phase(PWait, 10, "ninit_run");
      cycle();
      chk("ninit_emif", 32'(emif_reset_n), 0);
      chk("ninit_done", 32'(seq_done), 0);

      // Calibration fail and success in the same cycle.
      ninit_done = 1'b0; emif_cal_success = 1'b0; usb_phy_pll_locked = 1'b0;
      wait_phase(PEmifCal, 40, "calfail_cal");
      run(int'($urandom_range(0, 29)));
      emif_cal_success = 1'b1; emif_cal_fail = 1'b1;
      cycle();
      emif_cal_success = 1'b0; emif_cal_fail = 1'b0;
      wait_phase(PErr, 10, "calfail_err");
      cycle();
      chk("calfail_code", 32'(err_code), 1);
      chk("calfail_seqerr", 32'(seq_error), 1);
      chk("calfail_emif", 32'(emif_reset_n), 0);
      async_reset();

      // Calibration timeout twice.
      wait_phase(PErr, 200, "calto1");
      cycle();
      chk("calto1_code", 32'(err_code), 2);
      wait_phase(PWait, 20, "calto_retry");
      wait_phase(PErr, 200, "calto2");
      cycle();
      chk("calto2_code", 32'(err_code), 2);
      run(40);
      chk("calto_stuck", 32'(seq_error), 1);
      restart_req = 1'b1;
      cycle();
      restart_req = 1'b0;
      run(2);
      chk("calto_restart", 32'(seq_error), 0);
      chk("calto_latched", 32'(err_code), 2);

      // restart_req while calibrating.
      wait_phase(PEmifCal, 40, "restart_cal");
      run(5);
      chk("restart_emif_hi", 32'(emif_reset_n), 1);
      restart_req = 1'b1;
      cycle();
      restart_req = 1'b0;
      cycle();
      chk("restart_emif_lo", 32'(emif_reset_n), 0);

      // Asynchronous reset mid-calibration.
      wait_phase(PEmifCal, 40, "async_cal");
      run(10);
      chk("async_pre_emif", 32'(emif_reset_n), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_emif", 32'(emif_reset_n), 0);
      chk("async_code", 32'(err_code), 0);
      chk("async_seqerr", 32'(seq_error), 0);
      rst_n = 1'b1;
      async_reset();

      // Randomized soak.
      for (int i = 0; i < 3000; i++) begin
         ninit_done         = ($urandom_range(0, 99) < 3);
         emif_cal_success   = ($urandom_range(0, 99) < 10);
         emif_cal_fail      = ($urandom_range(0, 99) < 2);
         usb_phy_pll_locked = ($urandom_range(0, 99) < 85);
         restart_req        = ($urandom_range(0, 149) == 0);
         cycle();
         if ($urandom_range(0, 799) == 0) begin
            #($urandom_range(1, 3));
            async_reset();
         end
      end
      restart_req = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
